// File: rtl/piece_queue_gen.sv
// POLYTRIS piece generator: free-running Galois LFSR feeding a FWFT
// queue of upcoming pieces in uniform, N-bag or fixed-sequence mode.
module piece_queue_gen #(
  parameter int PIECE_W = 16,
  parameter int DEPTH = 4,
  parameter int NUM_TYPES = 7,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [1:0]                 mode,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_value,
  input  logic                       pop_req,
  output logic [PIECE_W-1:0]         piece_out,
  output logic                       piece_valid,
  output logic [LFSR_W-1:0]          noise_out,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int CW = $clog2(NUM_TYPES);
  localparam int SW = PIECE_W - 8;
  localparam int MW = 2 ** CW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [LFSR_W-1:0]    lfsr;
  logic [PIECE_W-1:0]   mem [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CNTW-1:0]      count;
  logic [SW-1:0]        serial;
  logic [NUM_TYPES-1:0] bag_mask;
  logic [CW-1:0]        fix_cnt;
  logic [1:0]           mode_q;
  logic [1:0]           state;

  logic [LFSR_W-1:0]    lfsr_step;
  logic [CW-1:0]        rnd, cand;
  logic                 bag_mode, fix_mode;
  logic [NUM_TYPES-1:0] mask_eff, mask_n;
  logic [MW-1:0]        mask_wide, cand_oh;
  logic                 cand_ok, pop_ok, push;
  logic [PIECE_W-1:0]   word, head_n;
  logic [CNTW-1:0]      count_n;
  logic [PW-1:0]        rd_n;
  logic [CW-1:0]        fix_n;
  logic [1:0]           state_n;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  assign rnd = lfsr[CW-1:0];
  assign bag_mode = (mode == 2'd1);
  assign fix_mode = (mode == 2'd2);
  assign pop_ok = pop_req && (count != '0);

  always_comb begin
    mask_eff = (mode != mode_q) ? '0 : bag_mask;
    mask_wide = '0;
    mask_wide[NUM_TYPES-1:0] = mask_eff;
    cand = fix_mode ? fix_cnt : rnd;
    cand_ok = 1'b1;
    unique case (1'b1)
      fix_mode: cand_ok = 1'b1;
      bag_mode: cand_ok = (int'(rnd) < NUM_TYPES) && !mask_wide[rnd];
      default:  cand_ok = (int'(rnd) < NUM_TYPES);
    endcase
    cand_oh = '0;
    cand_oh[cand] = 1'b1;
  end

  // a pop frees a slot in the same cycle, so a full queue still accepts
  assign push = (state != S_IDLE) && cand_ok &&
                ((count != CNTW'(DEPTH)) || pop_ok);
  assign word = {serial, {(8-CW){1'b0}}, cand};
  assign rd_n = rd_ptr + PW'(pop_ok);

  always_comb begin
    count_n = count;
    unique case ({push, pop_ok})
      2'b10:   count_n = count + CNTW'(1);
      2'b01:   count_n = count - CNTW'(1);
      default: count_n = count;
    endcase
    if (push && ((count == '0) ||
                 ((count == CNTW'(1)) && pop_ok)))
      head_n = word;
    else
      head_n = mem[rd_n];
    mask_n = mask_eff;
    if (push && bag_mode)
      mask_n = mask_eff | cand_oh[NUM_TYPES-1:0];
    if (&mask_n)
      mask_n = '0;
    fix_n = fix_cnt;
    if (push && fix_mode)
      fix_n = (fix_cnt == CW'(NUM_TYPES-1)) ? '0 : fix_cnt + CW'(1);
    state_n = state;
    unique case (state)
      S_IDLE: state_n = S_DRAW;
      S_DRAW: if (count_n == CNTW'(DEPTH)) state_n = S_FULL;
      S_FULL: if (pop_ok) state_n = S_DRAW;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset && !seed_load && push)
      mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      lfsr      <= SEED;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      piece_out <= '0;
      underflow <= 1'b0;
      serial    <= '0;
      bag_mask  <= '0;
      fix_cnt   <= '0;
      mode_q    <= 2'd0;
      state     <= S_IDLE;
    end else if (seed_load) begin
      lfsr      <= (seed_value == '0) ? SEED : seed_value;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
      serial    <= '0;
      bag_mask  <= '0;
      fix_cnt   <= '0;
      mode_q    <= mode;
      state     <= S_IDLE;
    end else begin
      lfsr      <= lfsr_step;
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_ptr + PW'(push);
      count     <= count_n;
      if (count_n != '0)
        piece_out <= head_n;
      underflow <= underflow | (pop_req && (count == '0));
      serial    <= serial + SW'(push);
      bag_mask  <= mask_n;
      fix_cnt   <= fix_n;
      mode_q    <= mode;
      state     <= state_n;
    end
  end

  assign piece_valid = (count != '0);
  assign noise_out = lfsr;
  assign queue_count = count;

endmodule

// File: tb/tb_piece_queue_gen.sv
// Directed bench for piece_queue_gen: fixed, bag and uniform draws,
// reseed/flush, underflow and reset behaviour.
module tb_piece_queue_gen;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  mode;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        pop_req;
  logic [15:0] piece_out;
  logic        piece_valid;
  logic [15:0] noise_out;
  logic [2:0]  queue_count;
  logic        underflow;

  int tests = 0;
  int fails = 0;
  int n;
  logic [15:0] expw;
  logic [7:0]  bag_t [14];
  logic [15:0] uni_a [8];
  logic [15:0] uni_b [8];
  logic [15:0] g0, g1;

  piece_queue_gen dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .mode        (mode),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
    .pop_req     (pop_req),
    .piece_out   (piece_out),
    .piece_valid (piece_valid),
    .noise_out   (noise_out),
    .queue_count (queue_count),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_piece"}, 32'(piece_out), 32'h0);
    chk({tag, "_valid"}, 32'(piece_valid), 32'h0);
    chk({tag, "_count"}, 32'(queue_count), 32'h0);
    chk({tag, "_underflow"}, 32'(underflow), 32'h0);
    chk({tag, "_noise"}, 32'(noise_out), 32'hACE1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!piece_valid && k < 1000) begin
      tick;
      k++;
    end
    chk(tag, 32'(piece_valid), 32'h1);
  endtask

  task automatic pop1;
    pop_req = 1'b1;
    tick;
    pop_req = 1'b0;
  endtask

  task automatic uni_run(output logic [15:0] seq [8]);
    seed_value = 16'h1234;
    seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    repeat (10) tick;
    for (int i = 0; i < 8; i++) begin
      wait_valid("uni_wait");
      seq[i] = piece_out;
      pop1;
    end
  endtask

  initial begin
    mode = 2'd2;
    reset_reset = 1'b1;
    seed_load = 1'b0;
    seed_value = 16'h0;
    pop_req = 1'b0;
    tick;
    tick;
    chk_reset("rst");

    reset_reset = 1'b0;
    n = 0;
    while (queue_count != 3'd4 && n < 6) begin
      tick;
      n++;
    end
    chk("fill_count", 32'(queue_count), 32'd4);
    chk("fill_head", 32'(piece_out), 32'h0000);

    // continuous pops at full: heads {serial, type} with type cycling 0..6
    for (int k = 0; k < 300; k++) begin
      expw = {8'(k), 8'(k % 7)};
      chk("fixed_head", 32'(piece_out), 32'(expw));
      pop_req = 1'b1;
      tick;
      chk("fixed_count", 32'(queue_count), 32'd4);
    end
    pop_req = 1'b0;
    chk("fixed_wrap_head", 32'(piece_out), 32'h2C06);

    seed_value = 16'h0;
    seed_load = 1'b1;
    pop_req = 1'b1;
    tick;
    seed_load = 1'b0;
    chk("seed_noise", 32'(noise_out), 32'hACE1);
    chk("seed_valid", 32'(piece_valid), 32'h0);
    chk("seed_count", 32'(queue_count), 32'h0);
    chk("seed_uf_clear", 32'(underflow), 32'h0);
    tick;
    pop_req = 1'b0;
    chk("underflow", 32'(underflow), 32'h1);

    tick;
    tick;
    chk("midfill_count", 32'(queue_count), 32'd2);
    chk("underflow_sticky", 32'(underflow), 32'h1);
    mode = 2'd1;
    reset_reset = 1'b1;
    tick;
    chk_reset("midrst");
    reset_reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      wait_valid("bag_wait");
      chk("bag_serial", 32'(piece_out[15:8]), 32'(i));
      bag_t[i] = piece_out[7:0];
      pop1;
    end
    g0 = '0;
    g1 = '0;
    for (int i = 0; i < 7; i++) begin
      g0 = g0 | (16'h1 << bag_t[i]);
      g1 = g1 | (16'h1 << bag_t[i+7]);
    end
    chk("bag_group0", 32'(g0), 32'h7F);
    chk("bag_group1", 32'(g1), 32'h7F);

    mode = 2'd0;
    tick;
    uni_run(uni_a);
    uni_run(uni_b);
    for (int i = 0; i < 8; i++) begin
      chk("uni_repeat", 32'(uni_b[i]), 32'(uni_a[i]));
      chk("uni_range", 32'(uni_a[i][7:0] < 8'd7), 32'h1);
      chk("uni_serial", 32'(uni_a[i][15:8]), 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
